// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, BCD limits and BCD/binary helpers for the alarm unit.
package alarm_pkg;
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_H   = 3'd1,
    SET_M   = 3'd2,
    RINGING = 3'd3,
    SNOOZE  = 3'd4
  } state_t;
  localparam logic [7:0] BCD_HMAX = 8'h23;
  localparam logic [7:0] BCD_MMAX = 8'h59;
  localparam logic [1:0] SET_NONE = 2'b00;
  localparam logic [1:0] SET_HOUR = 2'b01;
  localparam logic [1:0] SET_MIN  = 2'b10;
  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction
endpackage

// File: rtl/bcd_hm_add.sv
// bcd_hm_add: adds a binary minute increment to a BCD hh:mm, wrapping 59->00 and 23->00.
module bcd_hm_add import alarm_pkg::*; (
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [5:0] inc,
  output logic [7:0] hh_o,
  output logic [7:0] mm_o
);
  logic [6:0] m_sum;
  logic       wrap;
  assign m_sum = bcd2bin(mm) + 7'(inc);
  assign wrap  = m_sum >= 7'd60;
  assign mm_o  = bin2bcd(wrap ? m_sum - 7'd60 : m_sum);
  assign hh_o  = !wrap ? hh : (hh == BCD_HMAX ? 8'h00 : bin2bcd(bcd2bin(hh) + 7'd1));
endmodule

// File: rtl/alarm_unit.sv
// alarm_unit: settable alarm with ring timeout and snooze, driven by the wall clock's BCD time.
module alarm_unit import alarm_pkg::*; #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter logic [7:0]  RST_HOUR   = 8'h07,
  parameter logic [7:0]  RST_MIN    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic       en_alarm,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_minute,
  output logic [1:0] setting,
  output logic       ringing,
  output logic       snoozing
);
  state_t     state_q, state_d;
  logic [7:0] ah_q, ah_d, am_q, am_d, sh_q, sh_d, sm_q, sm_d, cnt_q, cnt_d;
  logic       match_a_q, match_s_q, match_a, match_s, fire_a, fire_s;
  logic [7:0] add_hh, add_mm, add_hh_o, add_mm_o;
  logic [5:0] add_inc;
  // One adder serves the snooze target (RINGING) and both SET increments;
  // feeding minute 59 with +1 makes it a pure hour increment.
  assign add_hh  = state_q == RINGING ? hour : ah_q;
  assign add_mm  = state_q == RINGING ? minute : (state_q == SET_H ? BCD_MMAX : am_q);
  assign add_inc = state_q == RINGING ? 6'(SNOOZE_MIN) : 6'd1;
  bcd_hm_add u_add (
    .hh   (add_hh),
    .mm   (add_mm),
    .inc  (add_inc),
    .hh_o (add_hh_o),
    .mm_o (add_mm_o)
  );
  assign match_a = hour == ah_q && minute == am_q && second == 8'h00;
  assign match_s = hour == sh_q && minute == sm_q && second == 8'h00;
  assign fire_a  = match_a & ~match_a_q;
  assign fire_s  = match_s & ~match_s_q;
  always_comb begin
    state_d = state_q;
    ah_d    = ah_q;
    am_d    = am_q;
    sh_d    = sh_q;
    sm_d    = sm_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (btn_mode) state_d = SET_H;
        else if (en_alarm && fire_a) begin
          state_d = RINGING;
          cnt_d   = 8'd0;
        end
      end
      SET_H: begin
        if (btn_mode) state_d = SET_M;
        else if (btn_inc) ah_d = add_hh_o;
      end
      SET_M: begin
        if (btn_mode) state_d = RUN;
        else if (btn_inc) am_d = add_mm_o;
      end
      RINGING: begin
        if (!en_alarm || btn_stop) state_d = RUN;
        else if (btn_snooze) begin
          state_d = SNOOZE;
          sh_d    = add_hh_o;
          sm_d    = add_mm_o;
        end else if (sec_tick) begin
          if (cnt_q == 8'(RING_SECS - 1)) state_d = RUN;
          else cnt_d = cnt_q + 8'd1;
        end
      end
      SNOOZE: begin
        if (!en_alarm || btn_stop) state_d = RUN;
        else if (fire_s) begin
          state_d = RINGING;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      ah_q      <= RST_HOUR;
      am_q      <= RST_MIN;
      sh_q      <= 8'h00;
      sm_q      <= 8'h00;
      cnt_q     <= 8'd0;
      match_a_q <= 1'b1;
      match_s_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ah_q      <= ah_d;
      am_q      <= am_d;
      sh_q      <= sh_d;
      sm_q      <= sm_d;
      cnt_q     <= cnt_d;
      match_a_q <= match_a;
      match_s_q <= match_s;
    end
  end
  assign alarm_hour   = ah_q;
  assign alarm_minute = am_q;
  assign ringing      = state_q == RINGING;
  assign snoozing     = state_q == SNOOZE;
  assign setting      = state_q == SET_H ? SET_HOUR : (state_q == SET_M ? SET_MIN : SET_NONE);
endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: directed scoreboard bench; stimulus queues expected outputs, a negedge monitor checks them.
module tb_alarm_unit;
  logic       clk = 1'b0;
  logic       rst_n, sec_tick, en_alarm, btn_mode, btn_inc, btn_snooze, btn_stop;
  logic [7:0] hour, minute, second, alarm_hour, alarm_minute;
  logic [1:0] setting;
  logic       ringing, snoozing;
  localparam logic [3:0] M = 4'b1000, I = 4'b0100, Z = 4'b0010, S = 4'b0001;
  int          checks = 0, errors = 0;
  logic [19:0] exp_q[$];
  string       name_q[$];
  logic [19:0] got, want;
  string       nm;
  always #5 clk = ~clk;
  alarm_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sec_tick     (sec_tick),
    .hour         (hour),
    .minute       (minute),
    .second       (second),
    .en_alarm     (en_alarm),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .btn_snooze   (btn_snooze),
    .btn_stop     (btn_stop),
    .alarm_hour   (alarm_hour),
    .alarm_minute (alarm_minute),
    .setting      (setting),
    .ringing      (ringing),
    .snoozing     (snoozing)
  );
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {ringing, snoozing, setting, alarm_hour, alarm_minute};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got ring=%b snz=%b set=%b alarm=%h:%h, want ring=%b snz=%b set=%b alarm=%h:%h",
                 nm, got[19], got[18], got[17:16], got[15:8], got[7:0],
                 want[19], want[18], want[17:16], want[15:8], want[7:0]);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic press(input logic [3:0] b);
    {btn_mode, btn_inc, btn_snooze, btn_stop} = b;
    tick(1);
    {btn_mode, btn_inc, btn_snooze, btn_stop} = 4'b0000;
  endtask
  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hour = h; minute = m; second = s;
  endtask
  task automatic expect_out(input string n, input logic r, input logic sz, input logic [1:0] st,
                            input logic [7:0] ah, input logic [7:0] am);
    name_q.push_back(n);
    exp_q.push_back({r, sz, st, ah, am});
  endtask
  initial begin
    rst_n = 1'b0; sec_tick = 1'b0; en_alarm = 1'b1;
    {btn_mode, btn_inc, btn_snooze, btn_stop} = 4'b0000;
    set_time(8'h07, 8'h00, 8'h00);
    tick(2);
    expect_out("reset", 0, 0, 2'b00, 8'h07, 8'h00);
    rst_n = 1'b1;
    tick(3);
    expect_out("release_on_match", 0, 0, 2'b00, 8'h07, 8'h00);
    press(M);
    expect_out("enter_set_h", 0, 0, 2'b01, 8'h07, 8'h00);
    repeat (3) press(I);
    expect_out("hour_09_to_10", 0, 0, 2'b01, 8'h10, 8'h00);
    repeat (14) press(I);
    expect_out("hour_23_to_00", 0, 0, 2'b01, 8'h00, 8'h00);
    press(M);
    expect_out("enter_set_m", 0, 0, 2'b10, 8'h00, 8'h00);
    repeat (10) press(I);
    expect_out("min_09_to_10", 0, 0, 2'b10, 8'h00, 8'h10);
    repeat (51) press(I);
    expect_out("min_wrap_no_carry", 0, 0, 2'b10, 8'h00, 8'h01);
    press(M | I);
    expect_out("mode_beats_inc", 0, 0, 2'b00, 8'h00, 8'h01);
    press(M); repeat (6) press(I); press(M); repeat (29) press(I); press(M);
    expect_out("alarm_0630", 0, 0, 2'b00, 8'h06, 8'h30);
    set_time(8'h06, 8'h29, 8'h59);
    tick(2);
    expect_out("pre_match", 0, 0, 2'b00, 8'h06, 8'h30);
    tick(1);
    set_time(8'h06, 8'h30, 8'h00);
    expect_out("match_cycle_low", 0, 0, 2'b00, 8'h06, 8'h30);
    tick(1);
    expect_out("ring_rise", 1, 0, 2'b00, 8'h06, 8'h30);
    second = 8'h01;
    repeat (59) begin
      sec_tick = 1'b1; tick(1); sec_tick = 1'b0; tick(1);
    end
    expect_out("ring_after_59", 1, 0, 2'b00, 8'h06, 8'h30);
    sec_tick = 1'b1; tick(1); sec_tick = 1'b0;
    expect_out("auto_off_60", 0, 0, 2'b00, 8'h06, 8'h30);
    set_time(8'h06, 8'h29, 8'h59);
    tick(2);
    set_time(8'h06, 8'h30, 8'h00);
    tick(1);
    expect_out("refire", 1, 0, 2'b00, 8'h06, 8'h30);
    press(S);
    expect_out("stop", 0, 0, 2'b00, 8'h06, 8'h30);
    tick(1000);
    expect_out("no_retrigger", 0, 0, 2'b00, 8'h06, 8'h30);
    press(M); repeat (17) press(I); press(M); repeat (28) press(I); press(M);
    expect_out("alarm_2358", 0, 0, 2'b00, 8'h23, 8'h58);
    set_time(8'h23, 8'h57, 8'h59);
    tick(2);
    set_time(8'h23, 8'h58, 8'h00);
    tick(1);
    expect_out("ring_2358", 1, 0, 2'b00, 8'h23, 8'h58);
    second = 8'h05;
    press(Z);
    expect_out("snooze", 0, 1, 2'b00, 8'h23, 8'h58);
    press(M);
    expect_out("snooze_ignores_mode", 0, 1, 2'b00, 8'h23, 8'h58);
    set_time(8'h00, 8'h02, 8'h59);
    tick(2);
    expect_out("snooze_wait", 0, 1, 2'b00, 8'h23, 8'h58);
    set_time(8'h00, 8'h03, 8'h00);
    tick(1);
    expect_out("snooze_ring_0003", 1, 0, 2'b00, 8'h23, 8'h58);
    press(Z | S);
    expect_out("stop_over_snooze", 0, 0, 2'b00, 8'h23, 8'h58);
    set_time(8'h23, 8'h57, 8'h59);
    tick(2);
    set_time(8'h23, 8'h58, 8'h00);
    tick(1);
    expect_out("ring_again", 1, 0, 2'b00, 8'h23, 8'h58);
    second = 8'h10;
    press(Z);
    expect_out("snooze_again", 0, 1, 2'b00, 8'h23, 8'h58);
    en_alarm = 1'b0;
    tick(1);
    expect_out("en_drop_in_snooze", 0, 0, 2'b00, 8'h23, 8'h58);
    en_alarm = 1'b1;
    set_time(8'h00, 8'h02, 8'h59);
    tick(2);
    set_time(8'h00, 8'h03, 8'h00);
    tick(3);
    expect_out("no_target_ring", 0, 0, 2'b00, 8'h23, 8'h58);
    set_time(8'h23, 8'h57, 8'h59);
    tick(1);
    press(M); press(M);
    set_time(8'h23, 8'h58, 8'h00);
    tick(3);
    expect_out("set_mask", 0, 0, 2'b10, 8'h23, 8'h58);
    press(M);
    tick(2);
    expect_out("exit_set_no_ring", 0, 0, 2'b00, 8'h23, 8'h58);
    tick(3);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
